// File: rtl/hazard_ctrl.sv
// Hazard sequencing for the 5-stage MIPS pipe: load-use bubble, EX branch flush, syscall halt/resume.
// Statistics counters are built only when HAZ_STATS_EN is defined; otherwise they read as zero.
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_id,
  input  logic [5:0]       func_id,
  input  logic [4:0]       ra_id,
  input  logic [4:0]       rb_id,
  input  logic [4:0]       rd_ex,
  input  logic             memrd_ex,
  input  logic             we_ex,
  input  logic             br_taken_ex,
  input  logic             syscall_ex,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc_ex,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_LU   = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      state_r;
  logic [1:0]      state_nx_s;
  logic            go_q_r;
  logic            redirect_r;
  logic [PC_W-1:0] redirect_pc_r;
  logic            uses_a_s;
  logic            uses_b_s;
  logic            lu_s;
  logic            hreq_s;
  logic            go_rise_s;
  logic            capture_s;
  logic            stall_ev_s;
  logic            flush_ev_s;

  // Decode whether the ID instruction reads rs
  always_comb begin
    case (op_id)
      6'h02, 6'h03: uses_a_s = 1'b0;
      default:      uses_a_s = 1'b1;
    endcase
  end

  // Decode whether the ID instruction reads rt
  always_comb begin
    uses_b_s = 1'b0;
    case (op_id)
      6'h00: begin
        case (func_id)
          6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2a, 6'h2b, 6'h0c: uses_b_s = 1'b1;
          default:                           uses_b_s = 1'b0;
        endcase
      end
      6'h04, 6'h05, 6'h2b, 6'h29: uses_b_s = 1'b1;
      default:                    uses_b_s = 1'b0;
    endcase
  end

  assign lu_s      = memrd_ex & we_ex & (rd_ex != 5'd0) &
                     (((rd_ex == ra_id) & uses_a_s) | ((rd_ex == rb_id) & uses_b_s));
  assign hreq_s    = syscall_ex & halt_req;
  assign go_rise_s = go & ~go_q_r;

  // Control outputs and next state; the redirect cycle ignores hazards
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nx_s = ST_RUN;
    capture_s  = 1'b0;
    stall_ev_s = 1'b0;
    flush_ev_s = 1'b0;
    case (state_r)
      ST_HALT: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (go_rise_s) state_nx_s = ST_RUN;
        else           state_nx_s = ST_HALT;
      end
      ST_RUN, ST_LU: begin
        if (redirect_r) begin
          ifid_flush = 1'b1;
        end else if (hreq_s) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          capture_s  = 1'b1;
          state_nx_s = ST_HALT;
        end else if (br_taken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_ev_s = 1'b1;
        end else if (lu_s && (state_r == ST_RUN)) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stall_ev_s = 1'b1;
          state_nx_s = ST_LU;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_RUN;
    endcase
  end

  // State, go edge history, redirect pulse and resume target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      go_q_r        <= 1'b0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= {PC_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      go_q_r     <= go;
      redirect_r <= (state_r == ST_HALT) & go_rise_s;
      if (capture_s) redirect_pc_r <= pc_ex + PC_W'(4);
      else           redirect_pc_r <= redirect_pc_r;
    end
  end

  assign halted      = (state_r == ST_HALT);
  assign redirect    = redirect_r;
  assign redirect_pc = redirect_pc_r;

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (state_r != ST_HALT) cycle_cnt_r <= sat_inc(cycle_cnt_r);
      if (stall_ev_s)         stall_cnt_r <= sat_inc(stall_cnt_r);
      if (flush_ev_s)         flush_cnt_r <= sat_inc(flush_cnt_r);
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  logic stats_unused_s;
  assign stats_unused_s = stall_ev_s ^ flush_ev_s;
  assign cycle_cnt = {CNT_W{1'b0}};
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan sequences plus random traffic against a behavioural model.
module tb_hazard_ctrl;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op_id, func_id;
  logic [4:0]  ra_id, rb_id, rd_ex;
  logic        memrd_ex, we_ex, br_taken_ex, syscall_ex, halt_req, go;
  logic [31:0] pc_ex;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, halted, redirect;
  logic [31:0] redirect_pc, cycle_cnt, stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, ifid_flush4, idex_flush4, halted4, redirect4;
  logic [31:0] redirect_pc4;
  logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .op_id(op_id), .func_id(func_id), .ra_id(ra_id), .rb_id(rb_id),
    .rd_ex(rd_ex), .memrd_ex(memrd_ex), .we_ex(we_ex), .br_taken_ex(br_taken_ex),
    .syscall_ex(syscall_ex), .halt_req(halt_req), .pc_ex(pc_ex), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .redirect(redirect), .redirect_pc(redirect_pc),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op_id(op_id), .func_id(func_id), .ra_id(ra_id), .rb_id(rb_id),
    .rd_ex(rd_ex), .memrd_ex(memrd_ex), .we_ex(we_ex), .br_taken_ex(br_taken_ex),
    .syscall_ex(syscall_ex), .halt_req(halt_req), .pc_ex(pc_ex), .go(go),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .halted(halted4), .redirect(redirect4), .redirect_pc(redirect_pc4),
    .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: what the pipe is doing this cycle, plus plain event tallies
  bit          m_halt, m_lu_prev, m_redir, m_go_q;
  logic [31:0] m_rpc;
  longint      m_cyc, m_stall, m_flush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (!STATS) return 64'd0;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit model_lu();
    bit ua, ub;
    ua = !(op_id inside {6'h02, 6'h03});
    ub = (op_id == 6'h00 && (func_id inside {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                             6'h2a, 6'h2b, 6'h0c}))
         || (op_id inside {6'h04, 6'h05, 6'h2b, 6'h29});
    return memrd_ex && we_ex && (rd_ex != 5'd0) &&
           ((rd_ex == ra_id && ua) || (rd_ex == rb_id && ub));
  endfunction

  task automatic model_reset();
    m_halt = 0; m_lu_prev = 0; m_redir = 0; m_go_q = 0;
    m_rpc = 32'd0; m_cyc = 0; m_stall = 0; m_flush = 0;
  endtask

  // Compare every DUT output with the model for the current cycle, then advance the model
  task automatic check_and_advance();
    bit e_pc, e_ifid, e_iff, e_idf;
    bit n_halt, n_redir, n_lu;
    logic [31:0] n_rpc;
    e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0;
    n_halt = m_halt; n_redir = 0; n_lu = 0; n_rpc = m_rpc;
    if (m_halt) begin
      e_pc = 0; e_ifid = 0; e_iff = 1; e_idf = 1;
      if (go && !m_go_q) begin n_halt = 0; n_redir = 1; end
    end else if (m_redir) begin
      e_iff = 1;
    end else if (syscall_ex && halt_req) begin
      e_pc = 0; e_ifid = 0; e_iff = 1; e_idf = 1;
      n_halt = 1; n_rpc = pc_ex + 32'd4;
    end else if (br_taken_ex) begin
      e_iff = 1; e_idf = 1;
    end else if (model_lu() && !m_lu_prev) begin
      e_pc = 0; e_ifid = 0; e_idf = 1; n_lu = 1;
    end
    chk("pc_en", pc_en, e_pc);
    chk("ifid_en", ifid_en, e_ifid);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_flush", idex_flush, e_idf);
    chk("halted", halted, m_halt);
    chk("redirect", redirect, m_redir);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("cycle_cnt", cycle_cnt, sat(m_cyc, 32));
    chk("stall_cnt", stall_cnt, sat(m_stall, 32));
    chk("flush_cnt", flush_cnt, sat(m_flush, 32));
    chk("cycle_cnt4", cycle_cnt4, sat(m_cyc, 4));
    chk("stall_cnt4", stall_cnt4, sat(m_stall, 4));
    chk("flush_cnt4", flush_cnt4, sat(m_flush, 4));
    chk("pc_en4", pc_en4, e_pc);
    if (!m_halt) m_cyc++;
    if (!m_halt && !m_redir && !(syscall_ex && halt_req) && br_taken_ex) m_flush++;
    if (n_lu) m_stall++;
    m_halt = n_halt; m_redir = n_redir; m_lu_prev = n_lu; m_rpc = n_rpc; m_go_q = go;
  endtask

  task automatic set_idle();
    op_id = 6'h00; func_id = 6'h00; ra_id = 5'd0; rb_id = 5'd0; rd_ex = 5'd0;
    memrd_ex = 0; we_ex = 0; br_taken_ex = 0; syscall_ex = 0; halt_req = 0; pc_ex = 32'd0;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic end_cycle();
    @(negedge clk);
    check_and_advance();
  endtask

  task automatic load_add(input logic [4:0] rd);
    memrd_ex = 1; we_ex = 1; rd_ex = rd; op_id = 6'h00; func_id = 6'h20; ra_id = 5'd1; rb_id = 5'd8;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    set_idle();
    rst_n = 0;
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_idex_flush", idex_flush, 0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_stall_cnt4", stall_cnt4, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    check_and_advance();
  endtask

  initial begin
    rst_n = 0;
    go = 0;
    set_idle();
    model_reset();
    #12;
    chk("init_halted", halted, 0);
    chk("init_pc_en", pc_en, 1);
    chk("init_cycle_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check_and_advance();

    // Load-use with add reading rt
    begin_cycle(); load_add(5'd8); end_cycle();
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_flush", idex_flush, 1);
    begin_cycle(); end_cycle();
    chk("lu_after_pc_en", pc_en, 1);
    chk("lu_stall_cnt", stall_cnt, STATS ? 32'd1 : 32'd0);
    begin_cycle(); load_add(5'd0); end_cycle();
    chk("lu_rd0_pc_en", pc_en, 1);
    begin_cycle(); load_add(5'd8); op_id = 6'h08; end_cycle();
    chk("addi_rt_pc_en", pc_en, 1);
    begin_cycle(); load_add(5'd8); op_id = 6'h08; ra_id = 5'd8; end_cycle();
    chk("addi_rs_pc_en", pc_en, 0);
    begin_cycle(); end_cycle();
    begin_cycle(); load_add(5'd8); br_taken_ex = 1; end_cycle();
    chk("br_lu_pc_en", pc_en, 1);
    chk("br_lu_ifid_flush", ifid_flush, 1);
    chk("br_lu_idex_flush", idex_flush, 1);
    begin_cycle(); end_cycle();
    chk("br_flush_cnt", flush_cnt, STATS ? 32'd1 : 32'd0);
    chk("br_stall_cnt", stall_cnt, STATS ? 32'd2 : 32'd0);

    // Halt with go already high, then resume on a fresh edge
    go = 1;
    begin_cycle(); end_cycle();
    begin_cycle(); syscall_ex = 1; halt_req = 1; pc_ex = 32'h0000_3000; end_cycle();
    chk("hreq_pc_en", pc_en, 0);
    for (int i = 0; i < 10; i++) begin
      begin_cycle(); load_add(5'd8); br_taken_ex = 1; end_cycle();
      chk("halt_halted", halted, 1);
      chk("halt_pc_en", pc_en, 0);
    end
    begin_cycle(); go = 0; end_cycle();
    begin_cycle(); go = 1; end_cycle();
    chk("edge_still_halted", halted, 1);
    begin_cycle(); end_cycle();
    chk("resume_redirect", redirect, 1);
    chk("resume_redirect_pc", redirect_pc, 32'h0000_3004);
    chk("resume_halted", halted, 0);
    begin_cycle(); end_cycle();
    chk("resume_redirect_once", redirect, 0);

    // PC wrap on capture
    begin_cycle(); syscall_ex = 1; halt_req = 1; pc_ex = 32'hFFFF_FFFC; go = 0; end_cycle();
    begin_cycle(); go = 1; end_cycle();
    begin_cycle(); end_cycle();
    chk("wrap_redirect_pc", redirect_pc, 32'h0000_0000);

    // 20 stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      begin_cycle(); load_add(5'd8); end_cycle();
      begin_cycle(); end_cycle();
    end
    chk("sat_stall_cnt4", stall_cnt4, STATS ? 4'd15 : 4'd0);

    // Reset inside HALT, then inside LU
    begin_cycle(); syscall_ex = 1; halt_req = 1; pc_ex = 32'h0000_1000; go = 0; end_cycle();
    begin_cycle(); end_cycle();
    async_reset();
    begin_cycle(); go = 1; end_cycle();
    begin_cycle(); end_cycle();
    chk("post_rst_no_redirect", redirect, 0);
    begin_cycle(); load_add(5'd8); end_cycle();
    async_reset();
    begin_cycle(); load_add(5'd8); end_cycle();
    chk("post_rst_lu_detect", pc_en, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) async_reset();
      begin_cycle();
      begin
        logic [5:0] ops[8];
        logic [5:0] fns[12];
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};
        fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h0c, 6'h00, 6'h08};
        op_id       = ops[$urandom_range(0, 7)];
        func_id     = fns[$urandom_range(0, 11)];
        ra_id       = 5'($urandom_range(0, 3));
        rb_id       = 5'($urandom_range(0, 3));
        rd_ex       = 5'($urandom_range(0, 3));
        memrd_ex    = 1'($urandom_range(0, 1));
        we_ex       = ($urandom_range(0, 3) != 0);
        br_taken_ex = ($urandom_range(0, 9) == 0);
        syscall_ex  = ($urandom_range(0, 19) == 0);
        halt_req    = 1'($urandom_range(0, 1));
        pc_ex       = $urandom();
        if ($urandom_range(0, 9) == 0) go = ~go;
      end
      end_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
